// File: rtl/instruction_encoder.sv
// Packs field sets into program words and streams them to program memory.
// Optional running XOR of written words: INSTRUCTION_ENCODER_CHECKSUM_EN.
module instruction_encoder #(
  parameter int INS_WIDTH  = 16,
  parameter int ADDR_W     = 8,
  parameter int DEPTH      = 256,
  parameter int ALU_OP_MAX = 5
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 Start,
  input  logic                 In_Valid,
  output logic                 In_Ready,
  input  logic [1:0]           In_Sec,
  input  logic [2:0]           In_Op,
  input  logic [1:0]           In_RNum,
  input  logic [7:0]           In_Data,
  input  logic                 In_Last,
  output logic                 Prog_WE,
  output logic [ADDR_W-1:0]    Prog_Addr,
  output logic [INS_WIDTH-1:0] Prog_Data,
  output logic                 Busy,
  output logic                 Done,
  output logic                 Err,
  output logic [ADDR_W:0]      Word_Cnt
`ifdef INSTRUCTION_ENCODER_CHECKSUM_EN
  ,
  output logic [INS_WIDTH-1:0] Checksum
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_DONE
  } state_t;

  localparam logic [2:0]        OP_MAX    = 3'(ALU_OP_MAX);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t                 state_q;
  state_t                 state_d;
  logic [ADDR_W-1:0]      ptr_q;
  logic [ADDR_W:0]        cnt_q;
  logic                   err_q;
  logic                   we_q;
  logic [ADDR_W-1:0]      addr_q;
  logic [INS_WIDTH-1:0]   data_q;
  logic [INS_WIDTH-1:0]   word;
  logic                   xfer;
  logic                   legal;
  logic                   reg_src;
  logic                   at_last;

  assign In_Ready  = (state_q == S_LOAD) && !Start && !Rst;
  assign xfer      = In_Valid && In_Ready;
  assign Busy      = (state_q == S_LOAD);
  assign Done      = (state_q == S_DONE);
  assign Err       = err_q;
  assign Word_Cnt  = cnt_q;
  assign Prog_WE   = we_q;
  assign Prog_Addr = addr_q;
  assign Prog_Data = data_q;
  assign at_last   = (ptr_q == LAST_ADDR);

  // Legality and packing of the offered field set.
  always_comb begin
    legal   = 1'b0;
    reg_src = 1'b0;
    word    = '0;
    if (In_Sec == 2'd3) begin
      legal   = (In_Op <= 3'd4);
      reg_src = (In_Op == 3'd0) || (In_Op == 3'd3);
    end else begin
      legal   = (In_Op <= OP_MAX);
      reg_src = (In_Sec == 2'd0);
    end
    word[INS_WIDTH-1 -: 2] = In_Sec;
    word[INS_WIDTH-3 -: 3] = In_Op;
    if (reg_src) begin
      word[INS_WIDTH-6 -: 2] = In_RNum;
    end else begin
      word[7:0] = In_Data;
    end
  end

  // Session state register.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Session sequencing: Start always reopens, last word or full memory closes.
  always_comb begin
    state_d = state_q;
    if (Start) begin
      state_d = S_LOAD;
    end else begin
      unique case (state_q)
        S_IDLE: state_d = S_IDLE;
        S_LOAD: begin
          if (xfer && (In_Last || (legal && at_last))) begin
            state_d = S_DONE;
          end
        end
        S_DONE: state_d = S_DONE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Write port, pointer, count and error flag.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      we_q   <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
      ptr_q  <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      we_q <= 1'b0;
      if (Start) begin
        ptr_q <= '0;
        cnt_q <= '0;
        err_q <= 1'b0;
      end else if (xfer) begin
        if (legal) begin
          we_q   <= 1'b1;
          addr_q <= ptr_q;
          data_q <= word;
          cnt_q  <= cnt_q + 1'b1;
          if (!at_last) begin
            ptr_q <= ptr_q + 1'b1;
          end
        end else begin
          err_q <= 1'b1;
        end
      end
    end
  end

`ifdef INSTRUCTION_ENCODER_CHECKSUM_EN
  logic [INS_WIDTH-1:0] cs_q;

  assign Checksum = cs_q;

  // Running XOR of every word written this session.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      cs_q <= '0;
    end else if (Start) begin
      cs_q <= '0;
    end else if (xfer && legal) begin
      cs_q <= cs_q ^ word;
    end
  end
`endif

endmodule
